// File: rtl/fxp_pkg.sv
// Shared Q16.16 constants, FSM state type and output saturation helper
// for the fixed-point dot product engine.
package fxp_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int MAX_LEN   = 16;
  localparam int LEN_W     = 5;
  localparam int ACC_W     = 54;
  localparam int PROD_W    = 2 * DATA_W - FRAC_BITS;

  localparam logic [DATA_W-1:0] Q_ONE = 32'h0001_0000;
  localparam logic [DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_MIN = 32'h8000_0000;

  // Clamp limits re-expressed at accumulator width so the comparison stays signed.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W){1'b0}}, Q_MAX};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W){1'b1}}, Q_MIN};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT
  } state_t;

  typedef struct packed {
    logic              ovf;
    logic [DATA_W-1:0] value;
  } sat_t;

  function automatic sat_t sat_q16(input logic signed [ACC_W-1:0] acc);
    sat_t res;
    res.ovf   = 1'b0;
    res.value = acc[DATA_W-1:0];
    if (acc > ACC_MAX) begin
      res.ovf   = 1'b1;
      res.value = Q_MAX;
    end else if (acc < ACC_MIN) begin
      res.ovf   = 1'b1;
      res.value = Q_MIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/fxp_mul_reg.sv
// Registered signed Q16.16 multiply; the full product is rescaled by an
// arithmetic shift (truncation toward -inf) and kept at 48 bits.
module fxp_mul_reg
  import fxp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_w,
  output logic [PROD_W-1:0] o_prod_q,
  output logic              o_prod_vld
);

  logic signed [2*DATA_W-1:0] w_full;
  logic        [PROD_W-1:0]   r_prod_q;
  logic                       r_prod_vld;

  assign w_full = $signed(i_x) * $signed(i_w);

  // prod_vld tracks the load strobe so each product is added exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_q   <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod_vld <= i_load;
      if (i_load) begin
        r_prod_q <= PROD_W'(w_full >>> FRAC_BITS);
      end
    end
  end

  assign o_prod_q   = r_prod_q;
  assign o_prod_vld = r_prod_vld;

endmodule

// File: rtl/fxp_dot_product_seq.sv
// Sequential Q16.16 dot product: y = bias + sum(x[i]*w[i]) using one shared
// registered multiplier, a wide accumulator and a saturating valid/ready output.
module fxp_dot_product_seq
  import fxp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] bias,
  output logic              err,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y_out,
  output logic              ovf
);

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_err;
  logic              w_len_bad;
  logic              w_accept;
  logic              w_hs;
  logic              w_last;
  logic              w_prod_vld;
  logic [PROD_W-1:0] w_prod_q;
  sat_t              w_sat;

  assign w_len_bad = len > LEN_W'(MAX_LEN);
  assign w_accept  = (r_state == IDLE) && start && !w_len_bad;
  assign w_hs      = (r_state == ACCUM) && in_valid;
  assign w_last    = w_hs && (r_cnt == (r_len - LEN_W'(1)));

  fxp_mul_reg u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_hs),
    .i_x       (x_in),
    .i_w       (w_in),
    .o_prod_q  (w_prod_q),
    .o_prod_vld(w_prod_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = (len == '0) ? OUTPUT : ACCUM;
      ACCUM:   if (w_last) w_next = DRAIN;
      DRAIN:   w_next = OUTPUT;
      OUTPUT:  if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A new start reloads the bias; otherwise the pending product is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == IDLE) && start && w_len_bad;
      if (w_accept) begin
        r_len <= len;
        r_cnt <= '0;
        r_acc <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
      end else begin
        if (w_hs) begin
          r_cnt <= r_cnt + LEN_W'(1);
        end
        if (w_prod_vld) begin
          r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod_q[PROD_W-1]}}, w_prod_q};
        end
      end
    end
  end

  assign w_sat     = sat_q16(r_acc);
  assign err       = r_err;
  assign busy      = (r_state != IDLE);
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == OUTPUT);
  assign y_out     = out_valid ? w_sat.value : '0;
  assign ovf       = out_valid & w_sat.ovf;

endmodule

// File: tb/tb_fxp_dot_product_seq.sv
// Self-checking bench for fxp_dot_product_seq: directed corner cases plus
// randomized operations compared against a plain-arithmetic reference model.
module tb_fxp_dot_product_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic [31:0] bias;
  logic        err;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_out;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] xs[16];
  logic [31:0] ws[16];

  localparam longint QMAXL = 64'sd2147483647;
  localparam longint QMINL = -64'sd2147483648;

  fxp_dot_product_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .bias     (bias),
    .err      (err),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_out    (y_out),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer sum of floor-rescaled products, clamped to Q16.16.
  function automatic logic [32:0] model(input logic [31:0] b, input int n);
    longint sum;
    sum = longint'($signed(b));
    for (int i = 0; i < n; i++) begin
      sum += (longint'($signed(xs[i])) * longint'($signed(ws[i]))) >>> 16;
    end
    if (sum > QMAXL) return {1'b1, 32'h7FFF_FFFF};
    if (sum < QMINL) return {1'b1, 32'h8000_0000};
    return {1'b0, sum[31:0]};
  endfunction

  function automatic logic [31:0] small_q();
    int v;
    v = int'($urandom_range(0, 524287)) - 262144;
    return v;
  endfunction

  task automatic start_op(input logic [31:0] b, input logic [4:0] l);
    start = 1'b1;
    bias  = b;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int pct, output bit tmo);
    int  i;
    int  guard;
    bit  hs;
    i     = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      in_valid = ($urandom_range(0, 99) < pct);
      x_in     = xs[i];
      w_in     = ws[i];
      hs       = in_valid && in_ready;
      @(negedge clk);
      if (hs) i++;
      guard++;
    end
    in_valid = 1'b0;
    tmo = (i < n);
  endtask

  task automatic wait_out(output int lat, output bit tmo);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    tmo = !out_valid;
  endtask

  task automatic run_op(input logic [31:0] b, input logic [4:0] l, input int pct,
                        output logic [31:0] y, output logic o, output int lat,
                        output bit tmo);
    bit ftmo;
    bit wtmo;
    ftmo = 1'b0;
    start_op(b, l);
    if (l != 0) feed(int'(l), pct, ftmo);
    wait_out(lat, wtmo);
    tmo = ftmo | wtmo;
    y = y_out;
    o = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, in_ready, out_valid, err, ovf, y_out} !== 37'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h want=0", {busy, in_ready, out_valid, err, ovf, y_out});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    int  lat;
    bit  tmo;
    xs[0] = 32'h0001_0000; ws[0] = 32'h0002_0000;
    xs[1] = 32'h0001_8000; ws[1] = 32'hFFFF_0000;
    xs[2] = 32'h0000_4000; ws[2] = 32'h0004_0000;
    start_op(32'h0000_8000, 5'd3);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accum_flags busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    feed(3, 100, tmo);
    wait_out(lat, tmo);
    checks++;
    if (tmo || lat !== 1) begin
      errors++;
      $display("[TB] FAIL full_rate_latency got=%0d timeout=%b want=1", lat, tmo);
    end
    checks++;
    if (y_out !== 32'h0002_0000 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_rate_result got=%h/%b want=00020000/0", y_out, ovf);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] y;
    logic        o;
    int          lat;
    bit          tmo;
    xs[0] = 32'h7FFF_0000; ws[0] = 32'h0002_0000;
    xs[1] = 32'h7FFF_0000; ws[1] = 32'h0002_0000;
    run_op(32'h0, 5'd2, 100, y, o, lat, tmo);
    checks++;
    if (tmo || y !== 32'h7FFF_FFFF || o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_pos got=%h/%b want=7fffffff/1 timeout=%b", y, o, tmo);
    end
    xs[0] = 32'h8000_0000; ws[0] = 32'h0001_0000;
    run_op(32'hFFFF_0000, 5'd1, 100, y, o, lat, tmo);
    checks++;
    if (tmo || y !== 32'h8000_0000 || o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_neg got=%h/%b want=80000000/1 timeout=%b", y, o, tmo);
    end
  endtask

  task automatic test_truncation();
    logic [31:0] y;
    logic        o;
    int          lat;
    bit          tmo;
    xs[0] = 32'h0000_0001; ws[0] = 32'h0000_8000;
    run_op(32'h0, 5'd1, 100, y, o, lat, tmo);
    checks++;
    if (tmo || y !== 32'h0000_0000 || o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trunc_pos got=%h/%b want=00000000/0", y, o);
    end
    xs[0] = 32'hFFFF_FFFF; ws[0] = 32'h0000_8000;
    run_op(32'h0, 5'd1, 100, y, o, lat, tmo);
    checks++;
    if (tmo || y !== 32'hFFFF_FFFF || o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL trunc_neg got=%h/%b want=ffffffff/0", y, o);
    end
  endtask

  task automatic test_len_edges();
    logic [31:0] y;
    logic        o;
    int          lat;
    bit          tmo;
    run_op(32'hFFFF_8000, 5'd0, 100, y, o, lat, tmo);
    checks++;
    if (tmo || lat !== 0 || y !== 32'hFFFF_8000 || o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len_zero got=%h/%b lat=%0d want=ffff8000/0 lat=0", y, o, lat);
    end
    start_op(32'h0, 5'd17);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len_bad_pulse err=%b busy=%b in_ready=%b want 1 0 0", err, busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len_bad_once err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y0;
    logic        o0;
    logic [31:0] y;
    logic        o;
    logic [32:0] exp;
    int          lat;
    bit          tmo;
    int          n;
    n = int'($urandom_range(4, 16));
    for (int i = 0; i < n; i++) begin
      xs[i] = small_q();
      ws[i] = small_q();
    end
    exp = model(32'h0003_0000, n);
    start_op(32'h0003_0000, 5'(n));
    feed(n, 50, tmo);
    wait_out(lat, tmo);
    y0 = y_out;
    o0 = ovf;
    start = 1'b1;
    len   = 5'd3;
    bias  = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      in_valid = $urandom_range(0, 1) == 1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || y_out !== y0 || ovf !== o0) begin
        errors++;
        $display("[TB] FAIL hold_stable cyc=%0d got=%b/%h/%b want=1/%h/%b", k, out_valid, y_out, ovf, y0, o0);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (tmo || {o0, y0} !== exp) begin
      errors++;
      $display("[TB] FAIL backpressure_result got=%b/%h want=%b/%h", o0, y0, exp[32], exp[31:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_in_output_ignored busy=%b want=0", busy);
    end
    run_op(32'h0003_0000, 5'(n), 100, y, o, lat, tmo);
    checks++;
    if (tmo || y !== y0 || o !== o0) begin
      errors++;
      $display("[TB] FAIL full_vs_stalled got=%h/%b want=%h/%b", y, o, y0, o0);
    end
  endtask

  task automatic test_random();
    logic [31:0] y;
    logic        o;
    logic [32:0] exp;
    logic [31:0] b;
    int          lat;
    bit          tmo;
    int          n;
    bit          wide;
    for (int t = 0; t < 10; t++) begin
      n    = int'($urandom_range(1, 16));
      wide = (t % 3 == 2);
      for (int i = 0; i < n; i++) begin
        xs[i] = wide ? $urandom() : small_q();
        ws[i] = wide ? $urandom() : small_q();
      end
      b   = wide ? $urandom() : small_q();
      exp = model(b, n);
      run_op(b, 5'(n), (t % 2 == 0) ? 100 : 70, y, o, lat, tmo);
      checks++;
      if (tmo || {o, y} !== exp) begin
        errors++;
        $display("[TB] FAIL random_op t=%0d len=%0d got=%b/%h want=%b/%h", t, n, o, y, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] y;
    logic        o;
    logic [32:0] exp;
    int          lat;
    bit          tmo;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 5; i++) begin
        xs[i] = small_q();
        ws[i] = small_q();
      end
      exp = model(32'hFFFE_0000, 5);
      run_op(32'hFFFE_0000, 5'd5, 100, y, o, lat, tmo);
      checks++;
      if (tmo || {o, y} !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back t=%0d got=%b/%h want=%b/%h", t, o, y, exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] y;
    logic        o;
    int          lat;
    bit          tmo;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 32'h0002_0000;
      ws[i] = 32'h0003_0000;
    end
    start_op(32'h0001_0000, 5'd4);
    feed(2, 100, tmo);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, err, ovf, y_out} !== 37'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op got=%h want=0", {busy, in_ready, out_valid, err, ovf, y_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xs[0] = 32'h0001_0000;
    ws[0] = 32'h0001_0000;
    run_op(32'h0, 5'd1, 100, y, o, lat, tmo);
    checks++;
    if (tmo || y !== 32'h0001_0000 || o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_stale_sum got=%h/%b want=00010000/0", y, o);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    bias      = '0;
    in_valid  = 1'b0;
    x_in      = '0;
    w_in      = '0;
    out_ready = 1'b0;
    test_reset();
    test_full_rate();
    test_saturation();
    test_truncation();
    test_len_edges();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
